program_fetch_controller: RTL and testbench

- Sequences instruction-byte fetch from the 128×8 program memory and hands each byte to the processor core over a valid/ready handshake.
- Adds the following to plain linear streaming:
  - start/stop control
  - jump (PC load)
  - end-of-program detection
  - backpressure handling
- Sits between the program memory (synchronous read, 1-cycle latency) and the core's decode stage.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/program_fetch_controller_if.sv | 34 +++
 rtl/fetch_pc_reg.sv | 74 +++++++
 rtl/program_fetch_controller.sv | 164 ++++++++++++++++
 tb/tb_program_fetch_controller.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the program fetch controller:
//   - default instruction width, PC width and program depth
//   - fetch FSM state encoding
//   - helper deciding whether a state counts as "busy"
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DEPTH  = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_VALID = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_e;

    // A fetch is in progress from the memory request until the core takes the byte.
    function automatic logic is_busy_state(input fetch_state_e s);
        return (s == ST_REQ) || (s == ST_RESP) || (s == ST_VALID);
    endfunction

endpackage

// File: rtl/program_fetch_controller_if.sv
// ---------------------------------------------------------------------------
// program_fetch_controller_if
// Bundles the two buses of the fetch controller:
//   - program memory read port: mem_en, mem_addr (to memory), mem_rdata (from memory)
//   - instruction handshake:    instr_valid, instr_data, instr_addr (to core),
//                               instr_ready (from core)
// Modports:
//   master - the fetch controller side
//   slave  - the memory/core side
// ---------------------------------------------------------------------------
interface program_fetch_controller_if
    import fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;

    modport master (
        output mem_en, mem_addr, instr_valid, instr_data, instr_addr,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_en, mem_addr, instr_valid, instr_data, instr_addr,
        output mem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program counter with clear / load / increment and jump-target range check.
// Ports:
//   clock, reset      - clock, asynchronous active-high reset
//   pc_clr_i          - force pc to 0 (highest priority)
//   pc_load_i         - load pc from load_addr_i
//   pc_inc_i          - pc <= pc + 1
//   jump_valid_i      - jump request, used only for the range check
//   load_addr_i       - jump target
//   pc_o              - current program counter
//   at_last_o         - pc is the last program location
//   jump_ok_o         - jump_valid_i with an in-range target (combinational)
//   jump_err_o        - registered one-cycle pulse for an out-of-range jump
// ---------------------------------------------------------------------------
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_clr_i,
    input  logic              pc_load_i,
    input  logic              pc_inc_i,
    input  logic              jump_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              at_last_o,
    output logic              jump_ok_o,
    output logic              jump_err_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              jump_err_q;
    logic              in_range_s;

    // When DEPTH fills the whole address space no target can be out of range.
    if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
        assign in_range_s = 1'b1;
    end else begin : g_part_range
        assign in_range_s = ({{(32-ADDR_W){1'b0}}, load_addr_i} < 32'(DEPTH));
    end

    assign jump_ok_o  = jump_valid_i & in_range_s;
    assign at_last_o  = (pc_q == ADDR_W'(DEPTH - 1));
    assign pc_o       = pc_q;
    assign jump_err_o = jump_err_q;

    // Next program counter: clear beats load beats increment.
    always_comb begin
        pc_d = pc_q;
        if (pc_clr_i) begin
            pc_d = {ADDR_W{1'b0}};
        end else if (pc_load_i) begin
            pc_d = load_addr_i;
        end else if (pc_inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and jump-error pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= {ADDR_W{1'b0}};
            jump_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            jump_err_q <= jump_valid_i & ~in_range_s;
        end
    end
endmodule

// File: rtl/program_fetch_controller.sv
// ---------------------------------------------------------------------------
// program_fetch_controller
// Fetches instruction bytes from a synchronous-read program memory (1-cycle
// latency) and hands them to the core over a valid/ready handshake, with
// start/stop control, jumps, end-of-program detection and backpressure.
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   start, stop    - begin/resume fetching, abort to IDLE (pc retained)
//   jump_valid,
//   jump_addr      - load pc with jump_addr
//   bus            - memory read port + instruction handshake (master side)
//   busy           - fetch in progress (REQ/RESP/VALID)
//   done           - end of program reached
//   jump_err       - one-cycle pulse on an out-of-range jump target
// Build option: define FETCH_LOOP_EN to wrap from the last address back to
// address 0 instead of stopping in DONE (done is then always 0).
// ---------------------------------------------------------------------------
module program_fetch_controller
    import fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        jump_valid,
    input  logic [ADDR_W-1:0]           jump_addr,
    program_fetch_controller_if.master  bus,
    output logic                        busy,
    output logic                        done,
    output logic                        jump_err
);
    fetch_state_e      state_q, state_d;
    logic              mem_en_q, instr_valid_q, busy_q, done_q;
    logic [DATA_W-1:0] instr_data_q;
    logic [ADDR_W-1:0] instr_addr_q;
    logic [ADDR_W-1:0] pc_s;
    logic              at_last_s, jump_ok_s, done_next_s;
    logic              pc_clr_s, pc_load_s, pc_inc_s, capture_s;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_pc (
        .clock        (clock),
        .reset        (reset),
        .pc_clr_i     (pc_clr_s),
        .pc_load_i    (pc_load_s),
        .pc_inc_i     (pc_inc_s),
        .jump_valid_i (jump_valid),
        .load_addr_i  (jump_addr),
        .pc_o         (pc_s),
        .at_last_o    (at_last_s),
        .jump_ok_o    (jump_ok_s),
        .jump_err_o   (jump_err)
    );

    // Next state and pc control; stop overrides jump, jump overrides normal flow.
    always_comb begin
        state_d   = state_q;
        pc_clr_s  = 1'b0;
        pc_load_s = 1'b0;
        pc_inc_s  = 1'b0;
        capture_s = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (jump_ok_s) begin
            // Any in-flight or held byte is dropped; a coincident handshake
            // still consumes the byte but the jump target replaces pc+1.
            pc_load_s = 1'b1;
            if (state_q == ST_IDLE) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_d = ST_RESP;
                end
                ST_RESP: begin
                    capture_s = 1'b1;
                    state_d   = ST_VALID;
                end
                ST_VALID: begin
                    if (bus.instr_ready) begin
                        if (at_last_s) begin
`ifdef FETCH_LOOP_EN
                            pc_clr_s = 1'b1;
                            state_d  = ST_REQ;
`else
                            state_d  = ST_DONE;
`endif
                        end else begin
                            pc_inc_s = 1'b1;
                            state_d  = ST_REQ;
                        end
                    end else begin
                        state_d = ST_VALID;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        pc_clr_s = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_LOOP_EN
    assign done_next_s = 1'b0;
`else
    assign done_next_s = (state_d == ST_DONE);
`endif

    // State register plus outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_en_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            instr_data_q  <= {DATA_W{1'b0}};
            instr_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            mem_en_q      <= (state_d == ST_REQ);
            instr_valid_q <= (state_d == ST_VALID);
            busy_q        <= is_busy_state(state_d);
            done_q        <= done_next_s;
            // Read data arrives in RESP; it is dropped if stop/jump intervenes.
            if (capture_s) begin
                instr_data_q <= bus.mem_rdata;
                instr_addr_q <= pc_s;
            end else begin
                instr_data_q <= instr_data_q;
                instr_addr_q <= instr_addr_q;
            end
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = pc_s;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_data  = instr_data_q;
    assign bus.instr_addr  = instr_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_program_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_program_fetch_controller
// Scoreboard bench: each scenario pushes the expected {addr,data} stream,
// a negedge monitor pops and compares on every instr_valid&&instr_ready.
// Memory model: mem[a] = a + 8'h10, synchronous read with 1-cycle latency.
// ---------------------------------------------------------------------------
module tb_program_fetch_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       jump_valid = 1'b0;
    logic [6:0] jump_addr = 7'd0;
    logic       busy, done, jump_err;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_hs = -1;
    logic       gap_chk = 1'b0;
    logic [14:0] sb[$];
    logic [14:0] exp_v;
    logic [7:0]  mem [128];

    program_fetch_controller_if bus ();

    program_fetch_controller dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .jump_err   (jump_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) + 8'h10;
    end

    always @(posedge clock) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard checker.
    always @(negedge clock) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_handshake: got addr %0d, expected none", bus.instr_addr);
            end else begin
                exp_v = sb.pop_front();
                chk("hs_addr", 32'(bus.instr_addr), 32'(exp_v[14:8]));
                chk("hs_data", 32'(bus.instr_data), 32'(exp_v[7:0]));
            end
            if (gap_chk) begin
                if (last_hs >= 0) chk("hs_gap", 32'(cyc - last_hs), 32'd3);
                last_hs = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) sb.push_back({7'(a), 8'(a) + 8'h10});
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_jump(input logic [6:0] a);
        jump_valid = 1'b1; jump_addr = a; tick(); jump_valid = 1'b0;
    endtask

    task automatic do_reset();
        sb.delete();
        bus.instr_ready = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

    task automatic wait_valid_addr(input logic [6:0] a, input int budget);
        int k = 0;
        while (!(bus.instr_valid && bus.instr_addr == a) && k < budget) begin
            tick(); k++;
        end
        chk("reach_valid_addr", 32'(bus.instr_valid && bus.instr_addr == a), 32'd1);
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(); k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.instr_ready = 1'b1;
        #2;
        // Reset values
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_data", 32'(bus.instr_data), 32'd0);
        chk("rst_addr", 32'(bus.instr_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_jerr", 32'(jump_err), 32'd0);

        // 1: full program stream, latency and throughput
        do_reset();
        push_range(0, 127);
`ifdef FETCH_LOOP_EN
        push_range(0, 0);
`endif
        gap_chk = 1'b1; last_hs = -1;
        pulse_start();
        chk("lat_c1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("lat_c1_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("lat_c1_valid", 32'(bus.instr_valid), 32'd0);
        chk("lat_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_c2_valid", 32'(bus.instr_valid), 32'd0);
        chk("lat_c2_mem_en", 32'(bus.mem_en), 32'd0);
        tick();
        chk("lat_c3_valid", 32'(bus.instr_valid), 32'd1);
        chk("lat_c3_addr", 32'(bus.instr_addr), 32'd0);
        chk("lat_c3_data", 32'(bus.instr_data), 32'h10);
        wait_sb_empty("stream_complete", 600);
        tick();
        gap_chk = 1'b0;
`ifdef FETCH_LOOP_EN
        chk("loop_done", 32'(done), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
        pulse_stop();
`else
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("end_done_held", 32'(done), 32'd1);
`endif

        // 2: backpressure at address 4
        do_reset();
        push_range(0, 5);
        pulse_start();
        wait_valid_addr(7'd4, 30);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp_addr", 32'(bus.instr_addr), 32'd4);
            chk("bp_data", 32'(bus.instr_data), 32'h14);
            chk("bp_mem_en", 32'(bus.mem_en), 32'd0);
        end
        bus.instr_ready = 1'b1;
        wait_sb_empty("bp_drain", 20);
        pulse_stop();
        chk("bp_stop_busy", 32'(busy), 32'd0);

        // 3: jump in VALID at 10 while not ready -> byte 10 never accepted
        do_reset();
        push_range(0, 9);
        push_range(100, 100);
        pulse_start();
        wait_valid_addr(7'd10, 60);
        bus.instr_ready = 1'b0;
        pulse_jump(7'd100);
        chk("jmp_nr_mem_en", 32'(bus.mem_en), 32'd1);
        chk("jmp_nr_mem_addr", 32'(bus.mem_addr), 32'd100);
        bus.instr_ready = 1'b1;
        wait_sb_empty("jmp_nr_drain", 20);
        pulse_stop();

        // 4: jump coincident with handshake at 10 -> 10 consumed, then 100
        do_reset();
        push_range(0, 10);
        push_range(100, 100);
        pulse_start();
        wait_valid_addr(7'd10, 60);
        pulse_jump(7'd100);
        chk("jmp_hs_mem_addr", 32'(bus.mem_addr), 32'd100);
        wait_sb_empty("jmp_hs_drain", 20);
        pulse_stop();

        // 5: stop in RESP at address 20, then resume
        do_reset();
        push_range(0, 19);
        pulse_start();
        begin
            int k = 0;
            while (!(bus.mem_en && bus.mem_addr == 7'd20) && k < 100) begin
                tick(); k++;
            end
        end
        chk("stop_reach_req20", 32'(bus.mem_en && bus.mem_addr == 7'd20), 32'd1);
        tick();
        chk("stop_in_resp_busy", 32'(busy), 32'd1);
        pulse_stop();
        chk("stop_valid", 32'(bus.instr_valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        chk("stop_idle_valid", 32'(bus.instr_valid), 32'd0);
        chk("stop_idle_mem_en", 32'(bus.mem_en), 32'd0);
        chk("stop_sb_drained", 32'(sb.size()), 32'd0);
        push_range(20, 20);
        pulse_start();
        chk("resume_mem_addr", 32'(bus.mem_addr), 32'd20);
        wait_sb_empty("resume_drain", 10);
        pulse_stop();

        // 6: asynchronous reset while holding VALID
        do_reset();
        push_range(0, 2);
        pulse_start();
        wait_valid_addr(7'd3, 30);
        bus.instr_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_data", 32'(bus.instr_data), 32'd0);
        chk("arst_addr", 32'(bus.instr_addr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        push_range(0, 0);
        pulse_start();
        chk("arst_restart_addr", 32'(bus.mem_addr), 32'd0);
        wait_sb_empty("arst_drain", 10);
        pulse_stop();

        // 7: jump in IDLE near the end, then jump out of DONE
        do_reset();
        pulse_jump(7'd126);
        chk("idle_jmp_busy", 32'(busy), 32'd0);
        chk("idle_jmp_mem_en", 32'(bus.mem_en), 32'd0);
        push_range(126, 127);
`ifdef FETCH_LOOP_EN
        push_range(0, 0);
`endif
        pulse_start();
        chk("idle_jmp_mem_addr", 32'(bus.mem_addr), 32'd126);
        wait_sb_empty("tail_drain", 20);
        tick();
`ifdef FETCH_LOOP_EN
        chk("tail_done", 32'(done), 32'd0);
        pulse_stop();
`else
        chk("tail_done", 32'(done), 32'd1);
        push_range(50, 50);
        pulse_jump(7'd50);
        chk("done_jmp_done", 32'(done), 32'd0);
        chk("done_jmp_mem_addr", 32'(bus.mem_addr), 32'd50);
        wait_sb_empty("done_jmp_drain", 10);
        pulse_stop();
`endif
        chk("final_jerr", 32'(jump_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
